// File: rtl/fifo1c_pkg.sv
// Shared types and helpers for the parameterised single-clock FIFO.
// Read-mode and output-pipe encodings plus the error-flag struct.
package fifo1c_pkg;

    localparam int MODE_NORMAL    = 0;
    localparam int MODE_SHOWAHEAD = 1;
    localparam int PIPE_OFF       = 0;
    localparam int PIPE_ON        = 1;

    typedef struct packed {
        logic underflow;
        logic overflow;
    } fifo_err_t;

    // Occupancy counters need one extra bit to represent DEPTH itself.
    function automatic int fifo_cnt_w(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/fifo1c_prm_if.sv
// Write/read/status bundle of fifo1c_prm; slave is the FIFO side, master the user.
interface fifo1c_prm_if #(
    parameter int DATA_WIDTH = 144,
    parameter int ADDR_WIDTH = 6
);
    import fifo1c_pkg::*;
    localparam int CW = fifo_cnt_w(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] data;
    logic                  wrreq;
    logic                  rdreq;
    logic [CW-1:0]         aful_thres;
    logic [CW-1:0]         aemp_thres;
    logic                  highest_clr;
    logic                  err_clr;
    logic [DATA_WIDTH-1:0] q;
    logic                  empty;
    logic                  full;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CW-1:0]         usedw;
    logic [CW-1:0]         highest_dw;
    logic                  overflow;
    logic                  underflow;
    logic [1:0]            err_sticky;

    modport slave (
        input  data, wrreq, rdreq, aful_thres, aemp_thres, highest_clr, err_clr,
        output q, empty, full, almost_full, almost_empty, usedw, highest_dw,
               overflow, underflow, err_sticky
    );

    modport master (
        output data, wrreq, rdreq, aful_thres, aemp_thres, highest_clr, err_clr,
        input  q, empty, full, almost_full, almost_empty, usedw, highest_dw,
               overflow, underflow, err_sticky
    );

endinterface

// File: rtl/ram1r1w_prm.sv
// Inferred 1R1W RAM with a registered read port; a same-address read returns old data.
module ram1r1w_prm #(
    parameter int DATA_WIDTH = 144,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Only the read register is reset so q comes up as zero; the array is not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/fifo1c_prm.sv
// Parameterised single-clock FIFO: normal or show-ahead read, optional q pipe,
// programmable almost flags, peak-occupancy watermark and sticky error flags.
module fifo1c_prm #(
    parameter int DATA_WIDTH = 144,
    parameter int ADDR_WIDTH = 6,
    parameter int SHOWAHEAD  = 0,
    parameter int PIPE       = 1
) (
    input logic         clk,
    input logic         rst_n,
    fifo1c_prm_if.slave bus
);
    import fifo1c_pkg::*;

    localparam int CW   = fifo_cnt_w(ADDR_WIDTH);
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam bit SA   = (SHOWAHEAD == MODE_SHOWAHEAD);
    localparam bit OREG = !SA && (PIPE == PIPE_ON);

    logic [ADDR_WIDTH-1:0] wptr, rptr;
    logic [CW-1:0]         cnt, cnt_nxt, ram_cnt, ram_cnt_nxt, highest;
    logic                  wr_acc, rd_acc, ram_rd, ovf_ev, udf_ev;
    logic                  head_vld, head_vld_nxt, empty_nxt;
    logic                  empty_r, full_r, aful_r, aemp_r, ovf_r, udf_r;
    logic                  rd_pend;
    fifo_err_t             err_r, err_nxt;
    logic [DATA_WIDTH-1:0] ram_q, q_r;

    ram1r1w_prm #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_acc),
        .waddr (wptr),
        .wdata (bus.data),
        .re    (ram_rd),
        .raddr (rptr),
        .rdata (ram_q)
    );

    // cnt is the user-visible occupancy; ram_cnt excludes the show-ahead head word.
    always_comb begin
        wr_acc = bus.wrreq && !full_r;
        rd_acc = bus.rdreq && !empty_r;
        ovf_ev = bus.wrreq && full_r;
        udf_ev = bus.rdreq && empty_r;
        if (SA) ram_rd = (ram_cnt != '0) && (!head_vld || rd_acc);
        else    ram_rd = rd_acc;
        head_vld_nxt = ram_rd || (head_vld && !rd_acc);
        cnt_nxt      = cnt + CW'(wr_acc) - CW'(rd_acc);
        ram_cnt_nxt  = ram_cnt + CW'(wr_acc) - CW'(ram_rd);
        empty_nxt    = SA ? !head_vld_nxt : (cnt_nxt == '0);
        // A set arriving alongside err_clr, on the request or the pulse cycle, survives.
        err_nxt           = bus.err_clr ? '0 : err_r;
        err_nxt.overflow  = err_nxt.overflow  | ovf_ev | ovf_r;
        err_nxt.underflow = err_nxt.underflow | udf_ev | udf_r;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            cnt      <= '0;
            ram_cnt  <= '0;
            head_vld <= 1'b0;
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
            aful_r   <= 1'b0;
            aemp_r   <= 1'b1;
            ovf_r    <= 1'b0;
            udf_r    <= 1'b0;
            err_r    <= '0;
            highest  <= '0;
            rd_pend  <= 1'b0;
            q_r      <= '0;
        end else begin
            wptr     <= wptr + ADDR_WIDTH'(wr_acc);
            rptr     <= rptr + ADDR_WIDTH'(ram_rd);
            cnt      <= cnt_nxt;
            ram_cnt  <= ram_cnt_nxt;
            head_vld <= head_vld_nxt;
            empty_r  <= empty_nxt;
            full_r   <= (cnt_nxt == DEPTH_C);
            aful_r   <= (cnt_nxt >= bus.aful_thres);
            aemp_r   <= (cnt_nxt <= bus.aemp_thres);
            ovf_r    <= ovf_ev;
            udf_r    <= udf_ev;
            err_r    <= err_nxt;
            if (bus.highest_clr)  highest <= cnt;
            else if (cnt > highest) highest <= cnt;
            rd_pend  <= ram_rd;
            if (rd_pend) q_r <= ram_q;
        end
    end

    assign bus.q            = OREG ? q_r : ram_q;
    assign bus.empty        = empty_r;
    assign bus.full         = full_r;
    assign bus.almost_full  = aful_r;
    assign bus.almost_empty = aemp_r;
    assign bus.usedw        = cnt;
    assign bus.highest_dw   = highest;
    assign bus.overflow     = ovf_r;
    assign bus.underflow    = udf_r;
    assign bus.err_sticky   = err_r;

endmodule

// File: doc/fifo1c_prm.md
Name: fifo1c_prm

Overview:
Parameterised single-clock synchronous FIFO. It replaces the fixed-geometry 64x144 wrapper with a generic width/depth block. It adds show-ahead read mode, runtime-programmable almost-full/almost-empty thresholds, and sticky error flags with a clear input. It sits in link_engine datapaths (frame buffering, stats queues) wherever a single-clock buffer is needed.

Parameters:
DATA_WIDTH, 144, word width in bits (1..512)
ADDR_WIDTH, 6, address bits; DEPTH = 2**ADDR_WIDTH (ADDR_WIDTH 2..12)
SHOWAHEAD, 0, 0 = normal read (q follows rdreq); 1 = first-word-fall-through
PIPE, 1, 1 = extra output register on q (normal mode only; ignored when SHOWAHEAD=1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
data  in  DATA_WIDTH  write data
wrreq  in  1  write request
rdreq  in  1  read request (SHOWAHEAD=1: acknowledge/pop of head word)
aful_thres  in  ADDR_WIDTH+1  almost-full threshold, quasi-static
aemp_thres  in  ADDR_WIDTH+1  almost-empty threshold, quasi-static
highest_clr  in  1  reload watermark
err_clr  in  1  clear sticky errors
q  out  DATA_WIDTH  read data
empty  out  1  no word available to read
full  out  1  usedw == DEPTH
almost_full  out  1  usedw >= aful_thres
almost_empty  out  1  usedw <= aemp_thres
usedw  out  ADDR_WIDTH+1  words held, 0..DEPTH
highest_dw  out  ADDR_WIDTH+1  peak usedw since last clear
overflow  out  1  one-cycle pulse: write rejected
underflow  out  1  one-cycle pulse: read rejected
err_sticky  out  2  {underflow seen, overflow seen}

Behaviour:
- Reset (async assert, sync deassert at the source):
  - q=0, usedw=0, highest_dw=0, empty=1, full=0, almost_empty=1, almost_full=0
  - overflow=0, underflow=0, err_sticky=0
  - Pointers cleared. RAM contents are not reset.
- Reset mid-operation discards all contents; first write after release lands at address 0.
- Accept rules (all flags registered):
  - Write accepted iff wrreq && !full. wrreq && full -> data dropped, overflow=1 next cycle.
  - Read accepted iff rdreq && !empty. rdreq && empty -> underflow=1 next cycle; q, pointers and usedw unchanged.
  - Simultaneous accepted read+write: usedw unchanged.
  - Full with wr+rd: read accepted, write rejected (full is the registered value).
  - Empty with wr+rd: write accepted, read rejected.
- Pointers: ADDR_WIDTH bits, natural wrap DEPTH-1 -> 0. full/empty are derived from usedw, not from pointer compare.
- usedw, full, empty, almost_* update the cycle after the accepted op.
  - almost_* compare against the current threshold inputs. A threshold > DEPTH never asserts almost_full.
- Memory: 1R1W inferred RAM, registered read, read-during-write to the same address returns old data (unreachable by construction).
- SHOWAHEAD=0:
  - PIPE=0: q valid 1 cycle after an accepted rdreq.
  - PIPE=1: q valid 2 cycles after an accepted rdreq.
  - q holds its value otherwise.
- SHOWAHEAD=1:
  - Internal one-entry output register; usedw counts it.
  - Write into an empty FIFO at cycle N -> empty=0 and q=word at N+2.
  - An accepted rdreq pops q. The next word is on q the following cycle if usedw>1; otherwise empty=1.
  - Back-to-back rdreq sustains 1 word/cycle.
- highest_dw:
  - Updates to usedw whenever usedw > highest_dw.
  - highest_clr loads the current usedw, and the clear wins over the same-cycle update.
  - Saturates at DEPTH.
- err_sticky: bits set on the overflow/underflow pulse. err_clr clears them; a set in the same cycle as err_clr wins.

Decomposition:
- Package fifo1c_pkg:
  - fifo_err_t, a struct {underflow, overflow}.
  - Function fifo_cnt_w(addr_w) = addr_w+1.
  - Localparams for mode encodings.
- Sub-module ram1r1w_prm (DATA_WIDTH, ADDR_WIDTH) holds the inferred RAM.
- Control, flags and show-ahead prefetch stay in fifo1c_prm.

Test Plan:
All scenarios use DATA_WIDTH=16, ADDR_WIDTH=3 (DEPTH=8) unless noted.
- Fill/drain, SHOWAHEAD=0, PIPE=1: write 0x0001..0x0008 -> full=1, usedw=8; 9th write 0x00FF -> overflow pulse, err_sticky=2'b01. Read 8 -> q=0x0001..0x0008, each 2 cycles after its rdreq; empty=1, usedw=0.
- Show-ahead: write 0xA5A5 at cycle N into empty FIFO -> empty=0 and q=0xA5A5 at N+2. Pop with 0xB6B6 queued -> q=0xB6B6 next cycle. Pop again -> empty=1.
- Thresholds: aful_thres=6, aemp_thres=2. After 2 writes: almost_empty=1, almost_full=0. After 6 writes: almost_full=1. Change aful_thres to 7 -> almost_full=0 next cycle.
- Boundary/simultaneous:
  - usedw=8, wrreq+rdreq -> usedw=7, overflow=1.
  - Empty, wrreq+rdreq -> usedw=1, underflow=1.
  - Steady wr+rd at usedw=4 across pointer wrap 7->0 -> data order preserved, usedw stays 4.
- Watermark/errors: peak usedw 5, drain to 1 -> highest_dw=5. highest_clr -> highest_dw=1. err_clr in the same cycle as an underflow -> err_sticky[1]=1.
- Reset mid-stream: assert rst_n=0 with usedw=5 -> all outputs reach reset values immediately (async). After release, write 0x1234 then read -> q=0x1234.
